// File: rtl/gx4000_palette_mixer.sv
// Plus-ASIC colour back end: CPU-writable 12-bit palette, two-stage pen lookup
// with per-channel expansion, and the programmable raster interrupt line counter.
module gx4000_palette_mixer #(
    parameter int CH_BITS  = 4,
    parameter int INK_PENS = 16,
    parameter int SPR_PENS = 16,
    parameter int PRI_BITS = 8
) (
    input  logic                                               clk_sys,
    input  logic                                               reset,
    input  logic                                               asic_enabled,
    input  logic [15:0]                                        cpu_addr,
    input  logic [7:0]                                         cpu_data,
    input  logic                                               cpu_wr,
    input  logic                                               pix_en,
    input  logic                                               de,
    input  logic [((INK_PENS > 1) ? $clog2(INK_PENS) : 1)-1:0] pen,
    input  logic [3:0]                                         spr_pen,
    input  logic                                               hsync,
    input  logic                                               vsync,
    input  logic                                               pri_ack,
    output logic [CH_BITS-1:0]                                 r_out,
    output logic [CH_BITS-1:0]                                 g_out,
    output logic [CH_BITS-1:0]                                 b_out,
    output logic                                               out_valid,
    output logic                                               pri_irq,
    output logic [PRI_BITS-1:0]                                line_count
);

    // Entry layout: ink pens 0..INK_PENS-1, border at INK_PENS, sprite pen k at
    // INK_PENS+k. Sprite pen 0 is transparent, so the border fills its slot.
    localparam int NUM_ENT = INK_PENS + SPR_PENS;
    localparam int IDX_W   = $clog2(NUM_ENT);

    localparam logic [IDX_W-1:0] BORDER_IDX = IDX_W'(INK_PENS);
    localparam logic [14:0]      ENT_LIMIT  = 15'(NUM_ENT);
    localparam logic [4:0]       SPR_LIMIT  = 5'(SPR_PENS);
    localparam logic [15:0]      PAL_BASE   = 16'h6400;
    localparam logic [15:0]      PRI_ADDR   = 16'h6800;

    logic [11:0]         palette [NUM_ENT];

    logic [15:0]         pal_off;
    logic [14:0]         pal_entry;
    logic [IDX_W-1:0]    pal_idx;
    logic                pal_hit;
    logic                pri_hit;
    logic [PRI_BITS+7:0] pri_wide;
    logic [PRI_BITS-1:0] pri_wdata;

    logic                spr_visible;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W-1:0]    s1_idx;
    logic                s1_valid;
    logic [11:0]         colour;

    logic                hsync_q;
    logic                vsync_q;
    logic                hs_rise;
    logic                vs_rise;
    logic [PRI_BITS-1:0] pri_line;
    logic [PRI_BITS-1:0] line_next;
    logic                pri_set;

    // ------------------------------------------------------------------
    // CPU register decode
    // ------------------------------------------------------------------
    assign pal_off   = cpu_addr - PAL_BASE;
    assign pal_entry = pal_off[15:1];
    assign pal_idx   = pal_entry[IDX_W-1:0];
    assign pal_hit   = cpu_wr && asic_enabled && (pal_entry < ENT_LIMIT);
    assign pri_hit   = cpu_wr && asic_enabled && (cpu_addr == PRI_ADDR);
    assign pri_wide  = {{PRI_BITS{1'b0}}, cpu_data};
    assign pri_wdata = pri_wide[PRI_BITS-1:0];

    // NOTE: the palette is a bank of flops rather than a RAM, so it can and
    // must be cleared by reset; a RAM macro would need a clearing sequencer.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                palette[i] <= '0;
            end
        end else if (pal_hit) begin
            if (cpu_addr[0]) begin
                palette[pal_idx][7:4] <= cpu_data[3:0];
            end else begin
                palette[pal_idx][11:8] <= cpu_data[7:4];
                palette[pal_idx][3:0]  <= cpu_data[3:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: pen selection
    // ------------------------------------------------------------------
    assign spr_visible = (spr_pen != 4'd0) && ({1'b0, spr_pen} < SPR_LIMIT);

    // NOTE: sel_idx takes its default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        sel_idx = IDX_W'(pen);
        if (!de) begin
            sel_idx = BORDER_IDX;
        end else if (spr_visible) begin
            sel_idx = BORDER_IDX + IDX_W'(spr_pen);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: palette lookup and output register
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments make the lookup see the palette as it was
    // before this edge, giving read-before-write against a same-cycle CPU write.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            s1_idx    <= '0;
            s1_valid  <= 1'b0;
            colour    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (pix_en) begin
                s1_idx    <= sel_idx;
                s1_valid  <= 1'b1;
                colour    <= palette[s1_idx];
                out_valid <= s1_valid;
            end
        end
    end

    // Replicating the nibble maps 4'hF to full scale at any output width.
    function automatic logic [CH_BITS-1:0] expand(input logic [3:0] c);
        logic [7:0] dup;
        dup = {c, c};
        return dup[7 -: CH_BITS];
    endfunction

    assign r_out = expand(colour[11:8]);
    assign g_out = expand(colour[7:4]);
    assign b_out = expand(colour[3:0]);

    // ------------------------------------------------------------------
    // Programmable raster interrupt
    // ------------------------------------------------------------------
    assign hs_rise   = hsync && !hsync_q;
    assign vs_rise   = vsync && !vsync_q;
    assign line_next = line_count + PRI_BITS'(1);
    assign pri_set   = hs_rise && !vs_rise && (line_next == pri_line) && (pri_line != '0);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
            line_count <= '0;
            pri_line   <= '0;
            pri_irq    <= 1'b0;
        end else begin
            hsync_q <= hsync;
            vsync_q <= vsync;

            if (vs_rise) begin
                line_count <= '0;
            end else if (hs_rise) begin
                line_count <= line_next;
            end

            // A new match outranks an acknowledge arriving in the same cycle.
            if (pri_set) begin
                pri_irq <= 1'b1;
            end else if (pri_ack) begin
                pri_irq <= 1'b0;
            end

            if (pri_hit) begin
                pri_line <= pri_wdata;
            end
        end
    end

endmodule

// File: tb/tb_gx4000_palette_mixer.sv
// Self-checking bench: directed scenarios followed by random traffic, compared
// against a pen-level reference model for 4-bit and 8-bit channel builds.
module tb_gx4000_palette_mixer;

    localparam int INK = 16;
    localparam int SPR = 16;
    localparam int PB  = 8;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        asic_enabled = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_data = '0;
    logic        cpu_wr = 1'b0;
    logic        pix_en = 1'b0;
    logic        de = 1'b0;
    logic [3:0]  pen = '0;
    logic [3:0]  spr_pen = '0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic        pri_ack = 1'b0;

    logic [3:0]  r4, g4, b4;
    logic [7:0]  r8, g8, b8;
    logic        ov4, ov8, irq4, irq8;
    logic [7:0]  lc4, lc8;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    gx4000_palette_mixer #(.CH_BITS(4), .INK_PENS(INK), .SPR_PENS(SPR), .PRI_BITS(PB)) dut4 (
        .clk_sys(clk_sys), .reset(reset), .asic_enabled(asic_enabled),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wr(cpu_wr),
        .pix_en(pix_en), .de(de), .pen(pen), .spr_pen(spr_pen),
        .hsync(hsync), .vsync(vsync), .pri_ack(pri_ack),
        .r_out(r4), .g_out(g4), .b_out(b4), .out_valid(ov4),
        .pri_irq(irq4), .line_count(lc4)
    );

    gx4000_palette_mixer #(.CH_BITS(8), .INK_PENS(INK), .SPR_PENS(SPR), .PRI_BITS(PB)) dut8 (
        .clk_sys(clk_sys), .reset(reset), .asic_enabled(asic_enabled),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wr(cpu_wr),
        .pix_en(pix_en), .de(de), .pen(pen), .spr_pen(spr_pen),
        .hsync(hsync), .vsync(vsync), .pri_ack(pri_ack),
        .r_out(r8), .g_out(g8), .b_out(b8), .out_valid(ov8),
        .pri_irq(irq8), .line_count(lc8)
    );

    // ------------------------------------------------------------------
    // Reference model: separate ink/border/sprite tables, a pipeline that
    // remembers the sampled pixel inputs, and a plain integer line counter.
    // ------------------------------------------------------------------
    logic [11:0] m_ink [INK];
    logic [11:0] m_spr [SPR];
    logic [11:0] m_border;
    logic        m_s1_full, m_s1_de;
    logic [3:0]  m_s1_pen, m_s1_spr;
    logic [11:0] m_col;
    logic        m_valid;
    int          m_pri_line, m_line;
    logic        m_irq, m_hs, m_vs;

    function automatic logic [11:0] colour_of(input logic d, input logic [3:0] p, input logic [3:0] s);
        if (!d) return m_border;
        if (s != 0 && int'(s) < SPR) return m_spr[s];
        return m_ink[p];
    endfunction

    function automatic logic [11:0] merge(input logic [11:0] old, input logic odd, input logic [7:0] d);
        if (odd) return {old[11:8], d[3:0], old[3:0]};
        return {d[7:4], old[7:4], d[3:0]};
    endfunction

    // {c,c} is c*17; keep the top 'bits' of that byte.
    function automatic logic [7:0] widen(input logic [3:0] c, input int bits);
        int v;
        v = int'(c) * 17;
        return 8'(v >> (8 - bits));
    endfunction

    task automatic model_edge();
        int  off, e, nl;
        bool_t_dummy: begin end
        if (reset) begin
            for (int i = 0; i < INK; i++) m_ink[i] = '0;
            for (int i = 0; i < SPR; i++) m_spr[i] = '0;
            m_border   = '0;
            m_s1_full  = 1'b0;
            m_s1_de    = 1'b1;   // cleared stage 1 points at ink pen 0
            m_s1_pen   = '0;
            m_s1_spr   = '0;
            m_col      = '0;
            m_valid    = 1'b0;
            m_pri_line = 0;
            m_line     = 0;
            m_irq      = 1'b0;
            m_hs       = 1'b0;
            m_vs       = 1'b0;
            return;
        end
        if (pix_en) begin
            m_col     = colour_of(m_s1_de, m_s1_pen, m_s1_spr);
            m_valid   = m_s1_full;
            m_s1_de   = de;
            m_s1_pen  = pen;
            m_s1_spr  = spr_pen;
            m_s1_full = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (vsync && !m_vs) begin
            m_line = 0;
        end else if (hsync && !m_hs) begin
            nl = (m_line + 1) % (1 << PB);
            m_line = nl;
            if (nl == m_pri_line && m_pri_line != 0) m_irq = 1'b1;
            else if (pri_ack) m_irq = 1'b0;
        end
        if (!(hsync && !m_hs && !(vsync && !m_vs)) && pri_ack) m_irq = 1'b0;
        m_hs = hsync;
        m_vs = vsync;
        if (cpu_wr && asic_enabled) begin
            if (cpu_addr == 16'h6800) m_pri_line = int'(cpu_data);
            off = (int'(cpu_addr) - 32'h6400) & 32'hFFFF;
            e   = off >> 1;
            if (e < INK) m_ink[e] = merge(m_ink[e], cpu_addr[0], cpu_data);
            else if (e == INK) m_border = merge(m_border, cpu_addr[0], cpu_data);
            else if (e < INK + SPR) m_spr[e-INK] = merge(m_spr[e-INK], cpu_addr[0], cpu_data);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic compare_all();
        check("r4", 32'(r4), 32'(widen(m_col[11:8], 4)));
        check("g4", 32'(g4), 32'(widen(m_col[7:4], 4)));
        check("b4", 32'(b4), 32'(widen(m_col[3:0], 4)));
        check("r8", 32'(r8), 32'(widen(m_col[11:8], 8)));
        check("g8", 32'(g8), 32'(widen(m_col[7:4], 8)));
        check("b8", 32'(b8), 32'(widen(m_col[3:0], 8)));
        check("out_valid4", 32'(ov4), 32'(m_valid));
        check("out_valid8", 32'(ov8), 32'(m_valid));
        check("pri_irq4", 32'(irq4), 32'(m_irq));
        check("pri_irq8", 32'(irq8), 32'(m_irq));
        check("line_count4", 32'(lc4), 32'(m_line));
        check("line_count8", 32'(lc8), 32'(m_line));
    endtask

    // Inputs are stable here; the model consumes them, then the DUT edge follows.
    task automatic step();
        model_edge();
        @(posedge clk_sys);
        #1;
        compare_all();
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_data = d;
        cpu_wr   = 1'b1;
        step();
        cpu_wr   = 1'b0;
    endtask

    task automatic pix(input int n);
        pix_en = 1'b1;
        repeat (n) step();
        pix_en = 1'b0;
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("rst_r", 32'(r8), 32'h0);
        check("rst_valid", 32'(ov4), 32'h0);
        check("rst_irq", 32'(irq4), 32'h0);
        check("rst_line", 32'(lc4), 32'h0);

        // Ten pixels with everything idle: black, out_valid from the 2nd edge on
        pix_en = 1'b1;
        step();
        check("ov_first_edge", 32'(ov4), 32'h0);
        step();
        check("ov_second_edge", 32'(ov4), 32'h1);
        repeat (8) step();
        pix_en = 1'b0;
        step();
        check("ov_idle", 32'(ov4), 32'h0);

        // Writes while locked are ignored
        asic_enabled = 1'b0;
        cpu_write(16'h6402, 8'hF3);
        cpu_write(16'h6403, 8'h05);
        pen = 4'd1; de = 1'b1; spr_pen = 4'd0;
        pix(2);
        check("locked_r", 32'(r4), 32'h0);
        check("locked_b", 32'(b4), 32'h0);

        // Ink pen 1
        asic_enabled = 1'b1;
        cpu_write(16'h6402, 8'hF3);
        cpu_write(16'h6403, 8'h05);
        pix(2);
        check("ink1_r", 32'(r4), 32'hF);
        check("ink1_g", 32'(g4), 32'h5);
        check("ink1_b", 32'(b4), 32'h3);
        step();
        check("hold_r", 32'(r4), 32'hF);

        // Border
        cpu_write(16'h6420, 8'h30);
        cpu_write(16'h6421, 8'h0C);
        de = 1'b0;
        pix(2);
        check("border_r", 32'(r4), 32'h3);
        check("border_g", 32'(g4), 32'hC);
        check("border_b", 32'(b4), 32'h0);

        // Sprite pen 2, then transparent pen falls back to ink
        cpu_write(16'h6424, 8'hA0);
        de = 1'b1; spr_pen = 4'd2;
        pix(2);
        check("spr2_r", 32'(r4), 32'hA);
        spr_pen = 4'd0;
        pix(2);
        check("spr0_ink_r", 32'(r4), 32'hF);

        // 8-bit channel expansion
        cpu_write(16'h6402, 8'hA0);
        pix(2);
        check("ch8_aa", 32'(r8), 32'hAA);
        cpu_write(16'h6402, 8'h10);
        pix(2);
        check("ch8_11", 32'(r8), 32'h11);

        // Raster interrupt on line 5
        cpu_write(16'h6800, 8'd5);
        vsync = 1'b1; step();
        vsync = 1'b0; step();
        check("pri_vs_line", 32'(lc4), 32'h0);
        for (int i = 1; i <= 5; i++) begin
            hsync = 1'b1; step();
            check("pri_line_inc", 32'(lc4), 32'(i));
            check("pri_irq_line", 32'(irq4), 32'(i == 5));
            hsync = 1'b0; step(); step();
        end
        pri_ack = 1'b1; step();
        pri_ack = 1'b0;
        check("pri_acked", 32'(irq4), 32'h0);
        cpu_write(16'h6800, 8'd6);
        hsync = 1'b1; pri_ack = 1'b1; step();
        check("pri_set_beats_ack", 32'(irq4), 32'h1);
        check("pri_line6", 32'(lc4), 32'h6);
        hsync = 1'b0; pri_ack = 1'b0; step();
        vsync = 1'b1; step();
        check("pri_vs_reset", 32'(lc4), 32'h0);
        vsync = 1'b0; step();
        hsync = 1'b1; vsync = 1'b1; step();
        check("pri_vs_over_hs", 32'(lc4), 32'h0);
        hsync = 1'b0; vsync = 1'b0; step();

        // Same-cycle write and lookup of pen 1
        cpu_write(16'h6402, 8'h50);
        pen = 4'd1; de = 1'b1; spr_pen = 4'd0;
        pix_en = 1'b1;
        step();
        cpu_addr = 16'h6402; cpu_data = 8'hF0; cpu_wr = 1'b1;
        step();
        cpu_wr = 1'b0;
        check("rbw_old", 32'(r4), 32'h5);
        step();
        check("rbw_new", 32'(r4), 32'hF);
        pix_en = 1'b0;

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            int sel;
            reset        = ($urandom_range(0, 299) == 0);
            asic_enabled = ($urandom_range(0, 7) != 0);
            cpu_wr       = ($urandom_range(0, 3) == 0);
            sel          = $urandom_range(0, 7);
            if (sel < 6) begin
                cpu_addr = 16'h6400 + 16'($urandom_range(0, 47));
                cpu_data = 8'($urandom);
            end else if (sel == 6) begin
                cpu_addr = 16'h6800;
                cpu_data = 8'($urandom_range(0, 12));
            end else begin
                cpu_addr = 16'($urandom);
                cpu_data = 8'($urandom);
            end
            pix_en  = 1'($urandom);
            de      = ($urandom_range(0, 3) != 0);
            pen     = 4'($urandom);
            spr_pen = 4'($urandom);
            if ($urandom_range(0, 2) == 0) hsync = !hsync;
            vsync   = ($urandom_range(0, 39) == 0);
            pri_ack = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
